lsu_arbiter: RTL

//  Two-requester arbiter and sequencer in front of the LSU (data mem + IO buffers).

---
 rtl/lsu_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_arbiter
//   Two-requester arbiter and sequencer in front of the LSU (data memory and
//   IO buffers). Port 0 is the pipeline MEM stage, port 1 is the debug /
//   program loader. One request is served at a time in three cycles:
//   IDLE (accept) -> ISSUE (LSU command valid) -> RESP (response pulse).
//   Illegal address / size / direction combinations are screened here and
//   answered with an error response; they never write the LSU.
//
//   Optional feature macro: LSU_ARB_RR_EN
//     defined   : round-robin between the two ports (last-grant register)
//     undefined : fixed priority, port 0 wins
//
// Ports
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_req_valid[1:0]        request valid, [0]=core, [1]=loader
//   o_req_ready[1:0]        one-hot grant in IDLE (combinational on valid)
//   i_req_wren[1:0]         1=store, 0=load
//   i_req_addr0/1           byte address per port
//   i_req_wdata0/1          store data per port
//   i_req_sl0/1             access type SB SH SW LB LH LW LBU LHU (0..7)
//   o_rsp_valid[1:0]        one-cycle response pulse to the owning port
//   o_rsp_rdata             load data, 0 for stores and errors
//   o_rsp_err               error flag, qualified by o_rsp_valid
//   o_lsu_wren/addr/st_data/slt_sl   LSU command (wren only during ISSUE)
//   i_lsu_ld_data           LSU registered load data (valid during RESP)
// ---------------------------------------------------------------------------
module lsu_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic [1:0]    i_req_valid,
   output logic [1:0]    o_req_ready,
   input  logic [1:0]    i_req_wren,
   input  logic [AW-1:0] i_req_addr0,
   input  logic [AW-1:0] i_req_addr1,
   input  logic [DW-1:0] i_req_wdata0,
   input  logic [DW-1:0] i_req_wdata1,
   input  logic [2:0]    i_req_sl0,
   input  logic [2:0]    i_req_sl1,
   output logic [1:0]    o_rsp_valid,
   output logic [DW-1:0] o_rsp_rdata,
   output logic          o_rsp_err,
   output logic          o_lsu_wren,
   output logic [AW-1:0] o_lsu_addr,
   output logic [DW-1:0] o_lsu_st_data,
   output logic [2:0]    o_lsu_slt_sl,
   input  logic [DW-1:0] i_lsu_ld_data
);

   localparam int unsigned SLW = 3;

   localparam logic [SLW-1:0] SL_SB  = 3'b000;
   localparam logic [SLW-1:0] SL_SH  = 3'b001;
   localparam logic [SLW-1:0] SL_SW  = 3'b010;
   localparam logic [SLW-1:0] SL_LH  = 3'b100;
   localparam logic [SLW-1:0] SL_LW  = 3'b101;
   localparam logic [SLW-1:0] SL_LHU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   typedef struct packed {
      logic            wren;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
      logic [SLW-1:0]  sl;
   } req_t;

   // LSU address map, decoded on the full 32-bit address.
   function automatic logic addr_mapped(input logic [AW-1:0] a);
      logic [19:0] page;
      page = a[31:12];
      return (a[31:16] == 16'h0000)
          || ((page >= 20'h10000) && (page <= 20'h10004))
          || (page == 20'h10010);
   endfunction

   // Unmapped, misaligned, or direction not matching the access type.
   function automatic logic req_illegal(input req_t r);
      logic is_store_sl;
      logic is_word;
      logic is_half;
      logic misaligned;
      is_store_sl = (r.sl == SL_SB) || (r.sl == SL_SH) || (r.sl == SL_SW);
      is_word     = (r.sl == SL_SW) || (r.sl == SL_LW);
      is_half     = (r.sl == SL_SH) || (r.sl == SL_LH) || (r.sl == SL_LHU);
      misaligned  = (is_word && (r.addr[1:0] != 2'b00)) || (is_half && r.addr[0]);
      return !addr_mapped(r.addr) || misaligned || (r.wren != is_store_sl);
   endfunction

   state_t state;
   logic   owner;
   logic   load_q;
   logic   err_q;

   logic   gnt_port;
   logic   accept;
   req_t   req0;
   req_t   req1;
   req_t   sel_req;
   logic   sel_err;

`ifdef LSU_ARB_RR_EN
   logic   last_grant;

   // Contention goes to the port that did not win last time.
   always_comb begin
      gnt_port = 1'b0;
      if (i_req_valid == 2'b11) begin
         gnt_port = ~last_grant;
      end else begin
         gnt_port = i_req_valid[1];
      end
   end
`else
   // Fixed priority: port 1 only when port 0 is idle.
   always_comb begin
      gnt_port = 1'b0;
      gnt_port = ~i_req_valid[0];
   end
`endif

   // Request mux, legality screen and combinational ready.
   always_comb begin
      req0        = '{wren: i_req_wren[0], addr: i_req_addr0, wdata: i_req_wdata0, sl: i_req_sl0};
      req1        = '{wren: i_req_wren[1], addr: i_req_addr1, wdata: i_req_wdata1, sl: i_req_sl1};
      sel_req     = gnt_port ? req1 : req0;
      sel_err     = req_illegal(sel_req);
      accept      = (state == S_IDLE) && (|i_req_valid);
      o_req_ready = 2'b00;
      if (accept) begin
         o_req_ready = gnt_port ? 2'b10 : 2'b01;
      end
   end

   // LSU load data is already registered; pass it through only in RESP.
   always_comb begin
      o_rsp_rdata = '0;
      if ((state == S_RESP) && load_q && !err_q) begin
         o_rsp_rdata = i_lsu_ld_data;
      end
   end

   // Sequencer: state plus registered LSU command and response outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state         <= S_IDLE;
         owner         <= 1'b0;
         load_q        <= 1'b0;
         err_q         <= 1'b0;
         o_rsp_valid   <= 2'b00;
         o_rsp_err     <= 1'b0;
         o_lsu_wren    <= 1'b0;
         o_lsu_addr    <= '0;
         o_lsu_st_data <= '0;
         o_lsu_slt_sl  <= SL_LW;
`ifdef LSU_ARB_RR_EN
         last_grant    <= 1'b1;
`endif
      end else begin
         o_lsu_wren  <= 1'b0;
         o_rsp_valid <= 2'b00;
         case (state)
            S_IDLE: begin
               o_rsp_err <= 1'b0;
               if (accept) begin
                  owner         <= gnt_port;
                  load_q        <= ~sel_req.wren;
                  err_q         <= sel_err;
                  o_lsu_wren    <= sel_req.wren & ~sel_err;
                  o_lsu_addr    <= sel_req.addr;
                  o_lsu_st_data <= sel_req.wdata;
                  o_lsu_slt_sl  <= sel_req.sl;
`ifdef LSU_ARB_RR_EN
                  last_grant    <= gnt_port;
`endif
                  state         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               o_rsp_valid[owner] <= 1'b1;
               o_rsp_err          <= err_q;
               state              <= S_RESP;
            end
            S_RESP: begin
               o_rsp_err <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               o_rsp_err <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
